load_store_unit: RTL and testbench

Initiator side of the data-memory interface: accepts one load/store request at a time from the CPU datapath and drives `MemRead`/`MemWrite`/address/write-data toward the word-organised data memory. It adds byte and halfword access on top of the word-only memory: sub-word loads are extracted and extended, and sub-word stores are done as read-modify-write. It sits between the execute stage and the data memory and replaces direct datapath-to-memory wiring.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states
// and the funct3 legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_e;

    // Unsigned sizes only make sense for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return store;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response channel and memory-side bus of the load/store unit.
interface lsu_cpu_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    modport master (output req_valid, req_store, req_funct3, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_store, req_funct3, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if #(parameter int WIDTH = 32);
    logic             MemRead;
    logic             MemWrite;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport master (output MemRead, MemWrite, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input MemRead, MemWrite, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: extracts and extends a load lane, and merges
// store data into a word for read-modify-write.
module lsu_lane_align #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       offset,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [WIDTH-1:0] st_data,
    output logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] st_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = word[{offset, 3'b000} +: 8];
        half_v  = word[{offset[1], 4'b0000} +: 16];
        ld_val  = word;
        st_word = st_data;
        case (size)
            2'b00: begin
                ld_val  = {{(WIDTH-8){sign_ext & byte_v[7]}}, byte_v};
                st_word = word;
                st_word[{offset, 3'b000} +: 8] = st_data[7:0];
            end
            2'b01: begin
                ld_val  = {{(WIDTH-16){sign_ext & half_v[15]}}, half_v};
                st_word = word;
                st_word[{offset[1], 4'b0000} +: 16] = st_data[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access over a word-only data memory, with
// sub-word stores done as read-modify-write. LSU_MISALIGN_TRAP_EN turns
// misaligned H/W accesses into errors instead of masking the low address bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    lsu_cpu_if.slave cpu,
    lsu_mem_if.master mem
);

    lsu_state_e       state_q, state_d;
    logic             store_q, store_d;
    logic [2:0]       f3_q, f3_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] rmw_q, rmw_d;
    logic             err_q, err_d;

    logic             misalign;
    logic [1:0]       offset;
    logic [WIDTH-1:0] align_word, ld_val, st_word;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (cpu.req_funct3[1:0] == 2'b01 && cpu.req_addr[0]) ||
                      (cpu.req_funct3[1:0] == 2'b10 && cpu.req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Offset is forced to the access alignment, which is also the masking
    // behaviour when misalignment is not trapped.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   offset = addr_q[1:0];
            2'b01:   offset = {addr_q[1], 1'b0};
            default: offset = 2'b00;
        endcase
    end

    assign align_word = (state_q == RMW_WR) ? rmw_q : mem.mem_rdata;

    lsu_lane_align #(.WIDTH(WIDTH)) u_align (
        .word    (align_word),
        .offset  (offset),
        .size    (f3_q[1:0]),
        .sign_ext(~f3_q[2]),
        .st_data (wdata_q),
        .ld_val  (ld_val),
        .st_word (st_word)
    );

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rmw_d   = rmw_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (cpu.req_valid) begin
                store_d = cpu.req_store;
                f3_d    = cpu.req_funct3;
                addr_d  = cpu.req_addr;
                wdata_d = cpu.req_wdata;
                rdata_d = '0;
                err_d   = f3_illegal(cpu.req_funct3, cpu.req_store) | misalign;
                if (err_d)                     state_d = RESP;
                else if (!cpu.req_store)       state_d = LOAD;
                else if (cpu.req_funct3 == F3_W) state_d = WRITE;
                else                           state_d = RMW_RD;
            end
            LOAD: begin
                rdata_d = ld_val;
                state_d = RESP;
            end
            WRITE:  state_d = RESP;
            RMW_RD: begin
                rmw_d   = mem.mem_rdata;
                state_d = RMW_WR;
            end
            RMW_WR: state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rmw_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rmw_q   <= rmw_d;
            err_q   <= err_d;
        end
    end

    // Strobes come straight from the state register so a reset kills them at once.
    assign cpu.req_ready  = (state_q == IDLE) && !reset;
    assign cpu.resp_valid = (state_q == RESP);
    assign cpu.resp_rdata = rdata_q;
    assign cpu.resp_err   = (state_q == RESP) && err_q;

    assign mem.MemRead   = (state_q == LOAD) || (state_q == RMW_RD);
    assign mem.MemWrite  = (state_q == WRITE) || (state_q == RMW_WR);
    assign mem.mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign mem.mem_wdata = (state_q == WRITE)  ? wdata_q :
                           (state_q == RMW_WR) ? st_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-organised memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_cpu_if #(.WIDTH(32)) cpu();
    lsu_mem_if #(.WIDTH(32)) mem();

    load_store_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .cpu  (cpu.slave),
        .mem  (mem.master)
    );

    logic [31:0] mem_arr [0:63];
    always @(posedge clk) if (mem.MemWrite) mem_arr[mem.mem_addr[7:2]] <= mem.mem_wdata;
    assign mem.mem_rdata = mem_arr[mem.mem_addr[7:2]];

    int n_tests = 0;
    int n_fail  = 0;

    int          r_lat;
    logic [31:0] r_rdata, r_wdata, r_waddr;
    logic        r_err, r_both;
    logic [7:0]  r_rd, r_wr;

    // Issues one request and records latency, strobe pattern per cycle and response.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int w;
        w = 0;
        @(negedge clk);
        while (!cpu.req_ready && w < 20) begin @(negedge clk); w++; end
        n_tests++;
        if (cpu.req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_wait got %b exp 1", cpu.req_ready); end
        cpu.req_store = st; cpu.req_funct3 = f3; cpu.req_addr = a; cpu.req_wdata = d;
        cpu.req_valid = 1'b1;
        @(posedge clk); #1 cpu.req_valid = 1'b0;
        r_lat = -1; r_rd = '0; r_wr = '0; r_both = 1'b0;
        r_rdata = '0; r_err = 1'b0; r_wdata = '0; r_waddr = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem.MemRead) r_rd[k-1] = 1'b1;
            if (mem.MemWrite) begin r_wr[k-1] = 1'b1; r_wdata = mem.mem_wdata; r_waddr = mem.mem_addr; end
            if (mem.MemRead && mem.MemWrite) r_both = 1'b1;
            if (cpu.resp_valid) begin r_lat = k; r_rdata = cpu.resp_rdata; r_err = cpu.resp_err; break; end
        end
    endtask

    task automatic test_reset;
        cpu.req_valid = 1'b0; cpu.req_store = 1'b0; cpu.req_funct3 = 3'b000;
        cpu.req_addr = '0; cpu.req_wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({cpu.req_ready, cpu.resp_valid, cpu.resp_err, mem.MemRead, mem.MemWrite} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 00000",
                {cpu.req_ready, cpu.resp_valid, cpu.resp_err, mem.MemRead, mem.MemWrite});
        end
        n_tests++;
        if ({cpu.resp_rdata, mem.mem_addr, mem.mem_wdata} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h exp 0", cpu.resp_rdata, mem.mem_addr, mem.mem_wdata);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (cpu.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b exp 1", cpu.req_ready); end
    endtask

    task automatic test_sw_lw;
        do_req(1'b1, F3_W, 32'h40, 32'hDEADBEEF);
        n_tests++; if (r_lat !== 2) begin n_fail++; $display("FAIL sw_lat got %0d exp 2", r_lat); end
        n_tests++; if (r_wr !== 8'b0000_0001 || r_rd !== 8'h0) begin n_fail++; $display("FAIL sw_strobes got rd=%b wr=%b exp rd=0 wr=00000001", r_rd, r_wr); end
        n_tests++; if (r_waddr !== 32'h40 || r_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_bus got %h/%h exp 00000040/deadbeef", r_waddr, r_wdata); end
        n_tests++; if (r_err !== 1'b0 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_resp got err=%b rdata=%h exp 0/0", r_err, r_rdata); end
        do_req(1'b0, F3_W, 32'h40, 32'h0);
        n_tests++; if (r_lat !== 2) begin n_fail++; $display("FAIL lw_lat got %0d exp 2", r_lat); end
        n_tests++; if (r_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h exp deadbeef", r_rdata); end
        n_tests++; if (r_rd !== 8'b0000_0001 || r_wr !== 8'h0) begin n_fail++; $display("FAIL lw_strobes got rd=%b wr=%b exp rd=00000001 wr=0", r_rd, r_wr); end
    endtask

    task automatic test_sb_rmw;
        do_req(1'b1, F3_W, 32'h40, 32'h11223344);
        do_req(1'b1, F3_B, 32'h41, 32'hFFFFFFAA);
        n_tests++; if (r_lat !== 3) begin n_fail++; $display("FAIL sb_lat got %0d exp 3", r_lat); end
        n_tests++; if (r_rd !== 8'b0000_0001 || r_wr !== 8'b0000_0010 || r_both !== 1'b0) begin
            n_fail++; $display("FAIL sb_strobes got rd=%b wr=%b both=%b exp rd=00000001 wr=00000010", r_rd, r_wr, r_both); end
        n_tests++; if (r_wdata !== 32'h1122AA44) begin n_fail++; $display("FAIL sb_merge got %h exp 1122aa44", r_wdata); end
        do_req(1'b0, F3_W, 32'h40, 32'h0);
        n_tests++; if (r_rdata !== 32'h1122AA44) begin n_fail++; $display("FAIL sb_readback got %h exp 1122aa44", r_rdata); end
    endtask

    task automatic test_load_ext;
        do_req(1'b1, F3_W, 32'h0, 32'h80007F80);
        do_req(1'b0, F3_B, 32'h0, 32'h0);
        n_tests++; if (r_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb0 got %h exp ffffff80", r_rdata); end
        do_req(1'b0, F3_BU, 32'h0, 32'h0);
        n_tests++; if (r_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu0 got %h exp 00000080", r_rdata); end
        do_req(1'b0, F3_H, 32'h2, 32'h0);
        n_tests++; if (r_rdata !== 32'hFFFF8000) begin n_fail++; $display("FAIL lh2 got %h exp ffff8000", r_rdata); end
        do_req(1'b0, F3_HU, 32'h2, 32'h0);
        n_tests++; if (r_rdata !== 32'h00008000) begin n_fail++; $display("FAIL lhu2 got %h exp 00008000", r_rdata); end
        do_req(1'b0, F3_B, 32'h1, 32'h0);
        n_tests++; if (r_rdata !== 32'h0000007F) begin n_fail++; $display("FAIL lb1 got %h exp 0000007f", r_rdata); end
        do_req(1'b0, F3_B, 32'h3, 32'h0);
        n_tests++; if (r_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb3 got %h exp ffffff80", r_rdata); end
        do_req(1'b0, F3_H, 32'h0, 32'h0);
        n_tests++; if (r_rdata !== 32'h00007F80) begin n_fail++; $display("FAIL lh0 got %h exp 00007f80", r_rdata); end
    endtask

    task automatic test_errors;
        do_req(1'b1, F3_W, 32'h44, 32'hCAFEF00D);
        do_req(1'b0, 3'b011, 32'h40, 32'h0);
        n_tests++; if (r_lat !== 1 || r_err !== 1'b1) begin n_fail++; $display("FAIL f3_011 got lat=%0d err=%b exp 1/1", r_lat, r_err); end
        n_tests++; if (r_rd !== 8'h0 || r_wr !== 8'h0) begin n_fail++; $display("FAIL f3_011_strobe got rd=%b wr=%b exp 0/0", r_rd, r_wr); end
        do_req(1'b1, F3_BU, 32'h40, 32'h0);
        n_tests++; if (r_lat !== 1 || r_err !== 1'b1 || r_wr !== 8'h0) begin n_fail++; $display("FAIL sbu_err got lat=%0d err=%b wr=%b exp 1/1/0", r_lat, r_err, r_wr); end
        do_req(1'b0, F3_W, 32'h45, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_tests++; if (r_lat !== 1 || r_err !== 1'b1 || r_rd !== 8'h0) begin n_fail++; $display("FAIL lw45_trap got lat=%0d err=%b rd=%b exp 1/1/0", r_lat, r_err, r_rd); end
        do_req(1'b0, F3_H, 32'h43, 32'h0);
        n_tests++; if (r_lat !== 1 || r_err !== 1'b1) begin n_fail++; $display("FAIL lh43_trap got lat=%0d err=%b exp 1/1", r_lat, r_err); end
`else
        n_tests++; if (r_lat !== 2 || r_err !== 1'b0 || r_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lw45_mask got lat=%0d err=%b data=%h exp 2/0/cafef00d", r_lat, r_err, r_rdata); end
        do_req(1'b0, F3_H, 32'h43, 32'h0);
        n_tests++; if (r_err !== 1'b0 || r_rdata !== 32'h00001122) begin n_fail++; $display("FAIL lh43_mask got err=%b data=%h exp 0/00001122", r_err, r_rdata); end
`endif
        do_req(1'b0, F3_W, 32'h40, 32'h0);
        n_tests++; if (r_err !== 1'b0 || r_rdata !== 32'h1122AA44) begin n_fail++; $display("FAIL post_err_lw got err=%b data=%h exp 0/1122aa44", r_err, r_rdata); end
    endtask

    task automatic test_back_to_back;
        int acc, resp_at, resp2_at;
        acc = 0; resp_at = -1; resp2_at = -1;
        @(negedge clk);
        cpu.req_store = 1'b1; cpu.req_funct3 = F3_H; cpu.req_addr = 32'h42; cpu.req_wdata = 32'h5555BEEF;
        cpu.req_valid = 1'b1;
        if (cpu.req_ready) acc++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (cpu.req_ready) acc++;
            if (cpu.resp_valid) resp_at = k;
        end
        n_tests++; if (acc !== 1 || resp_at !== 3) begin n_fail++; $display("FAIL hold_single got acc=%0d resp_at=%0d exp 1/3", acc, resp_at); end
        @(negedge clk);
        n_tests++; if (cpu.req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_after_resp got %b exp 1", cpu.req_ready); end
        @(posedge clk); #1 cpu.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (cpu.resp_valid && resp2_at < 0) resp2_at = k;
        end
        n_tests++; if (resp2_at !== 3) begin n_fail++; $display("FAIL hold_second_lat got %0d exp 3", resp2_at); end
        do_req(1'b0, F3_W, 32'h40, 32'h0);
        n_tests++; if (r_rdata !== 32'hBEEFAA44) begin n_fail++; $display("FAIL sh_readback got %h exp beefaa44", r_rdata); end
    endtask

    task automatic test_reset_rmw;
        do_req(1'b1, F3_W, 32'h48, 32'h55667788);
        @(negedge clk);
        cpu.req_store = 1'b1; cpu.req_funct3 = F3_B; cpu.req_addr = 32'h48; cpu.req_wdata = 32'hAA;
        cpu.req_valid = 1'b1;
        @(posedge clk); #1 cpu.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (mem.MemWrite !== 1'b1) begin n_fail++; $display("FAIL rmw_wr_reached got %b exp 1", mem.MemWrite); end
        reset = 1'b1;
        #1;
        n_tests++; if ({mem.MemWrite, mem.MemRead, cpu.req_ready, cpu.resp_valid} !== 4'b0 || mem.mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_rmw got wr=%b rd=%b rdy=%b rv=%b wdata=%h exp all 0",
                mem.MemWrite, mem.MemRead, cpu.req_ready, cpu.resp_valid, mem.mem_wdata); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++; if (cpu.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_ready got %b exp 1", cpu.req_ready); end
        do_req(1'b0, F3_W, 32'h48, 32'h0);
        n_tests++; if (r_rdata !== 32'h55667788) begin n_fail++; $display("FAIL rst_rmw_word got %h exp 55667788", r_rdata); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_sb_rmw();
        test_load_ext();
        test_errors();
        test_back_to_back();
        test_reset_rmw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
